// File: rtl/axil_cfg_master_if.sv
// Command/response streams plus AXI4-Lite channels for axil_cfg_master.
// The master modport is the axil_cfg_master side; the slave modport is the far end.
interface axil_cfg_master_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_write;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [1:0]            rsp_resp;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        input  rsp_ready,
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        output rsp_ready,
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_cfg_master.sv
// Single-outstanding AXI4-Lite master driven by a valid/ready command stream.
// Optional handshake timeout is enabled by defining AXIL_TIMEOUT_EN.
module axil_cfg_master #(
    parameter int ADDR_WIDTH     = 13,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    axil_cfg_master_if.master bus,
`ifdef AXIL_TIMEOUT_EN
    output logic timeout_err,
`endif
    output logic busy
);
    typedef enum logic [2:0] {IDLE, WRITE, WR_RESP, READ, RD_DATA, RESP} state_t;

    state_t                r_state, w_stateNxt;
    logic                  r_cmdReady, w_cmdReadyNxt;
    logic [ADDR_WIDTH-1:0] r_awAddr, w_awAddrNxt;
    logic                  r_awValid, w_awValidNxt;
    logic [DATA_WIDTH-1:0] r_wData, w_wDataNxt;
    logic                  r_wValid, w_wValidNxt;
    logic                  r_bReady, w_bReadyNxt;
    logic [ADDR_WIDTH-1:0] r_arAddr, w_arAddrNxt;
    logic                  r_arValid, w_arValidNxt;
    logic                  r_rReady, w_rReadyNxt;
    logic                  r_rspValid, w_rspValidNxt;
    logic                  r_rspWrite, w_rspWriteNxt;
    logic [DATA_WIDTH-1:0] r_rspRdata, w_rspRdataNxt;
    logic [1:0]            r_rspResp, w_rspRespNxt;
    logic                  r_awDone, w_awDoneNxt;
    logic                  r_wDone, w_wDoneNxt;
    logic                  r_busy, w_busyNxt;

    logic w_awHs, w_wHs, w_arHs;
    assign w_awHs = r_awValid && bus.awready;
    assign w_wHs  = r_wValid && bus.wready;
    assign w_arHs = r_arValid && bus.arready;

`ifdef AXIL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] r_tmoCnt;
    logic             r_timeoutErr;
    logic             w_waitState, w_timeout;

    assign w_waitState = (r_state == WRITE) || (r_state == WR_RESP) ||
                         (r_state == READ)  || (r_state == RD_DATA);
    assign w_timeout   = w_waitState && (r_tmoCnt == TMO_LAST);

    // Counter restarts on every state change, so it measures time spent waiting in one state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmoCnt     <= '0;
            r_timeoutErr <= 1'b0;
        end else begin
            if (w_stateNxt != r_state)
                r_tmoCnt <= '0;
            else if (w_waitState)
                r_tmoCnt <= r_tmoCnt + TMO_W'(1);
            if (w_timeout)
                r_timeoutErr <= 1'b1;
        end
    end

    assign timeout_err = r_timeoutErr;
`endif

    // Readies (bready/rready) rise the cycle after entering their wait state, so no
    // handshake can complete on a stale bvalid/rvalid seen during the state change.
    always_comb begin
        w_stateNxt    = r_state;
        w_cmdReadyNxt = r_cmdReady;
        w_awAddrNxt   = r_awAddr;
        w_awValidNxt  = r_awValid;
        w_wDataNxt    = r_wData;
        w_wValidNxt   = r_wValid;
        w_bReadyNxt   = r_bReady;
        w_arAddrNxt   = r_arAddr;
        w_arValidNxt  = r_arValid;
        w_rReadyNxt   = r_rReady;
        w_rspValidNxt = r_rspValid;
        w_rspWriteNxt = r_rspWrite;
        w_rspRdataNxt = r_rspRdata;
        w_rspRespNxt  = r_rspResp;
        w_awDoneNxt   = r_awDone;
        w_wDoneNxt    = r_wDone;

        case (r_state)
            IDLE: begin
                if (r_cmdReady && bus.cmd_valid) begin
                    w_cmdReadyNxt = 1'b0;
                    w_rspWriteNxt = bus.cmd_write;
                    w_awDoneNxt   = 1'b0;
                    w_wDoneNxt    = 1'b0;
                    if (bus.cmd_write) begin
                        w_awAddrNxt  = bus.cmd_addr;
                        w_wDataNxt   = bus.cmd_wdata;
                        w_awValidNxt = 1'b1;
                        w_wValidNxt  = 1'b1;
                        w_stateNxt   = WRITE;
                    end else begin
                        w_arAddrNxt  = bus.cmd_addr;
                        w_arValidNxt = 1'b1;
                        w_stateNxt   = READ;
                    end
                end else begin
                    w_cmdReadyNxt = 1'b1;
                end
            end
            WRITE: begin
                if (w_awHs) begin
                    w_awValidNxt = 1'b0;
                    w_awDoneNxt  = 1'b1;
                end
                if (w_wHs) begin
                    w_wValidNxt = 1'b0;
                    w_wDoneNxt  = 1'b1;
                end
                if (w_awDoneNxt && w_wDoneNxt)
                    w_stateNxt = WR_RESP;
            end
            WR_RESP: begin
                if (!r_bReady) begin
                    w_bReadyNxt = 1'b1;
                end else if (bus.bvalid) begin
                    w_bReadyNxt   = 1'b0;
                    w_rspRespNxt  = bus.bresp;
                    w_rspRdataNxt = '0;
                    w_rspValidNxt = 1'b1;
                    w_stateNxt    = RESP;
                end
            end
            READ: begin
                if (w_arHs) begin
                    w_arValidNxt = 1'b0;
                    w_stateNxt   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (!r_rReady) begin
                    w_rReadyNxt = 1'b1;
                end else if (bus.rvalid) begin
                    w_rReadyNxt   = 1'b0;
                    w_rspRespNxt  = bus.rresp;
                    w_rspRdataNxt = bus.rdata;
                    w_rspValidNxt = 1'b1;
                    w_stateNxt    = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_rspValidNxt = 1'b0;
                    w_cmdReadyNxt = 1'b1;
                    w_stateNxt    = IDLE;
                end
            end
            default: w_stateNxt = IDLE;
        endcase

`ifdef AXIL_TIMEOUT_EN
        if (w_timeout) begin
            w_awValidNxt  = 1'b0;
            w_wValidNxt   = 1'b0;
            w_bReadyNxt   = 1'b0;
            w_arValidNxt  = 1'b0;
            w_rReadyNxt   = 1'b0;
            w_rspRespNxt  = 2'b10;
            w_rspRdataNxt = '0;
            w_rspValidNxt = 1'b1;
            w_stateNxt    = RESP;
        end
`endif

        w_busyNxt = (w_stateNxt != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cmdReady <= 1'b0;
            r_awAddr   <= '0;
            r_awValid  <= 1'b0;
            r_wData    <= '0;
            r_wValid   <= 1'b0;
            r_bReady   <= 1'b0;
            r_arAddr   <= '0;
            r_arValid  <= 1'b0;
            r_rReady   <= 1'b0;
            r_rspValid <= 1'b0;
            r_rspWrite <= 1'b0;
            r_rspRdata <= '0;
            r_rspResp  <= '0;
            r_awDone   <= 1'b0;
            r_wDone    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_stateNxt;
            r_cmdReady <= w_cmdReadyNxt;
            r_awAddr   <= w_awAddrNxt;
            r_awValid  <= w_awValidNxt;
            r_wData    <= w_wDataNxt;
            r_wValid   <= w_wValidNxt;
            r_bReady   <= w_bReadyNxt;
            r_arAddr   <= w_arAddrNxt;
            r_arValid  <= w_arValidNxt;
            r_rReady   <= w_rReadyNxt;
            r_rspValid <= w_rspValidNxt;
            r_rspWrite <= w_rspWriteNxt;
            r_rspRdata <= w_rspRdataNxt;
            r_rspResp  <= w_rspRespNxt;
            r_awDone   <= w_awDoneNxt;
            r_wDone    <= w_wDoneNxt;
            r_busy     <= w_busyNxt;
        end
    end

    assign bus.cmd_ready = r_cmdReady;
    assign bus.awaddr    = r_awAddr;
    assign bus.awvalid   = r_awValid;
    assign bus.wdata     = r_wData;
    assign bus.wvalid    = r_wValid;
    assign bus.bready    = r_bReady;
    assign bus.araddr    = r_arAddr;
    assign bus.arvalid   = r_arValid;
    assign bus.rready    = r_rReady;
    assign bus.rsp_valid = r_rspValid;
    assign bus.rsp_write = r_rspWrite;
    assign bus.rsp_rdata = r_rspRdata;
    assign bus.rsp_resp  = r_rspResp;
    assign busy          = r_busy;
endmodule

// File: tb/tb_axil_cfg_master.sv
// Self-checking bench for axil_cfg_master: table of transactions with a reactive AXI slave,
// a response scoreboard, and hand sequences for reset abort and (with AXIL_TIMEOUT_EN) timeout.
module tb_axil_cfg_master;
    localparam int AW    = 13;
    localparam int DW    = 32;
    localparam int LIMIT = 200;

    typedef struct {
        logic          isWrite;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            awDelay;
        int            wDelay;
        int            bDelay;
        int            arDelay;
        int            rDelay;
        int            rspDelay;
        logic [DW-1:0] slvRdata;
        logic [1:0]    slvResp;
        logic [DW-1:0] expRdata;
        logic [1:0]    expResp;
        int            expLatency;
    } vec_t;

    typedef struct {
        logic          write;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
    } rsp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    logic busy;
`ifdef AXIL_TIMEOUT_EN
    logic timeoutErr;
`endif

    int   checkCount = 0;
    int   passCount  = 0;
    int   cycleCnt   = 0;
    int   awHs = 0, wHs = 0, bHs = 0, arHs = 0, rHs = 0;
    rsp_t sbQ[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    axil_cfg_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axil_cfg_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
`ifdef AXIL_TIMEOUT_EN
        .timeout_err(timeoutErr),
`endif
        .busy(busy)
    );

    // Cycle counter and per-channel handshake counters observed at the active edge
    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
        if (bus.awvalid && bus.awready) awHs <= awHs + 1;
        if (bus.wvalid && bus.wready)   wHs  <= wHs + 1;
        if (bus.bvalid && bus.bready)   bHs  <= bHs + 1;
        if (bus.arvalid && bus.arready) arHs <= arHs + 1;
        if (bus.rvalid && bus.rready)   rHs  <= rHs + 1;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    // Address-channel slave: waits for valid, holds ready low for 'delay' cycles, then handshakes
    task automatic addrChannel(input bit isAr, input logic [AW-1:0] addr, input int delay, input string tag);
        int n = 0;
        bit held = 1;
        while (!(isAr ? bus.arvalid : bus.awvalid) && n < LIMIT) begin @(negedge clk); n++; end
        checkOutput({tag, isAr ? "_arvalid" : "_awvalid"}, isAr ? bus.arvalid : bus.awvalid, 1);
        if (!(isAr ? bus.arvalid : bus.awvalid)) return;
        checkOutput({tag, isAr ? "_araddr" : "_awaddr"}, isAr ? bus.araddr : bus.awaddr, addr);
        repeat (delay) begin
            @(negedge clk);
            if (isAr ? (!bus.arvalid || bus.araddr !== addr) : (!bus.awvalid || bus.awaddr !== addr))
                held = 0;
        end
        if (isAr) bus.arready = 1'b1; else bus.awready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
        bus.awready = 1'b0;
        if (delay > 0) checkOutput({tag, isAr ? "_ar_held" : "_aw_held"}, held, 1);
        checkOutput({tag, isAr ? "_ar_drop" : "_aw_drop"}, isAr ? bus.arvalid : bus.awvalid, 0);
    endtask

    task automatic wChannel(input logic [DW-1:0] data, input int delay, input string tag);
        int n = 0;
        bit held = 1;
        while (!bus.wvalid && n < LIMIT) begin @(negedge clk); n++; end
        checkOutput({tag, "_wvalid"}, bus.wvalid, 1);
        if (!bus.wvalid) return;
        checkOutput({tag, "_wdata"}, bus.wdata, data);
        repeat (delay) begin
            @(negedge clk);
            if (!bus.wvalid || bus.wdata !== data) held = 0;
        end
        bus.wready = 1'b1;
        @(negedge clk);
        bus.wready = 1'b0;
        if (delay > 0) checkOutput({tag, "_w_held"}, held, 1);
        checkOutput({tag, "_w_drop"}, bus.wvalid, 0);
    endtask

    // Response-channel slave for B (isR=0) or R (isR=1)
    task automatic respChannel(input bit isR, input int delay, input logic [DW-1:0] data,
                               input logic [1:0] resp, input string tag);
        int n = 0;
        while (!(isR ? bus.rready : bus.bready) && n < LIMIT) begin @(negedge clk); n++; end
        checkOutput({tag, isR ? "_rready" : "_bready"}, isR ? bus.rready : bus.bready, 1);
        if (!(isR ? bus.rready : bus.bready)) return;
        repeat (delay) @(negedge clk);
        if (isR) begin bus.rvalid = 1'b1; bus.rdata = data; bus.rresp = resp; end
        else     begin bus.bvalid = 1'b1; bus.bresp = resp; end
        @(negedge clk);
        bus.rvalid = 1'b0;
        bus.bvalid = 1'b0;
        checkOutput({tag, isR ? "_rready_drop" : "_bready_drop"}, isR ? bus.rready : bus.bready, 0);
    endtask

    // Waits for rsp_valid, compares against the scoreboard, optionally stalls with bus noise
    task automatic consumeResponse(input int c0, input int expLat, input int hold, input string tag);
        int   n = 0;
        bit   stable = 1, readyLow = 1;
        rsp_t exp, got;
        while (!bus.rsp_valid && n < LIMIT) begin @(negedge clk); n++; end
        checkOutput({tag, "_rsp_valid"}, bus.rsp_valid, 1);
        if (!bus.rsp_valid) return;
        if (expLat >= 0) checkOutput({tag, "_latency"}, cycleCnt - c0 - 1, expLat);
        checkOutput({tag, "_sb_pending"}, sbQ.size(), 1);
        if (sbQ.size() == 0) return;
        exp = sbQ.pop_front();
        got.write = bus.rsp_write;
        got.rdata = bus.rsp_rdata;
        got.resp  = bus.rsp_resp;
        checkOutput({tag, "_rsp_write"}, got.write, exp.write);
        checkOutput({tag, "_rsp_rdata"}, got.rdata, exp.rdata);
        checkOutput({tag, "_rsp_resp"},  got.resp,  exp.resp);
        repeat (hold) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_write !== got.write ||
                bus.rsp_rdata !== got.rdata || bus.rsp_resp !== got.resp) stable = 0;
            if (bus.cmd_ready) readyLow = 0;
            bus.bvalid = 1'b1; bus.bresp = 2'b11;
            bus.rvalid = 1'b1; bus.rdata = 32'h0BAD_0BAD; bus.rresp = 2'b01;
        end
        if (hold > 0) begin
            checkOutput({tag, "_rsp_stable"}, stable, 1);
            checkOutput({tag, "_cmd_ready_held_low"}, readyLow, 1);
        end
        bus.bvalid = 1'b0; bus.rvalid = 1'b0; bus.bresp = '0; bus.rresp = '0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checkOutput({tag, "_rsp_valid_drop"}, bus.rsp_valid, 0);
        checkOutput({tag, "_cmd_ready_back"}, bus.cmd_ready, 1);
        checkOutput({tag, "_busy_clear"}, busy, 0);
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        int n = 0;
        int c0;
        int awBase = awHs, wBase = wHs, bBase = bHs, arBase = arHs, rBase = rHs;
        bus.cmd_write = v.isWrite;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < LIMIT) begin @(negedge clk); n++; end
        checkOutput({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        if (!bus.cmd_ready) begin bus.cmd_valid = 1'b0; return; end
        c0 = cycleCnt;
        sbQ.push_back('{v.isWrite, v.expRdata, v.expResp});
        fork
            begin
                @(negedge clk);
                bus.cmd_valid = 1'b0;
                bus.cmd_write = ~v.isWrite;
                bus.cmd_addr  = ~v.addr;
                bus.cmd_wdata = ~v.wdata;
                checkOutput({tag, "_busy"}, busy, 1);
                checkOutput({tag, "_cmd_ready_low"}, bus.cmd_ready, 0);
            end
            if (v.isWrite) begin
                fork
                    addrChannel(1'b0, v.addr, v.awDelay, tag);
                    wChannel(v.wdata, v.wDelay, tag);
                join
                respChannel(1'b0, v.bDelay, '0, v.slvResp, tag);
            end else begin
                addrChannel(1'b1, v.addr, v.arDelay, tag);
                respChannel(1'b1, v.rDelay, v.slvRdata, v.slvResp, tag);
            end
            consumeResponse(c0, v.expLatency, v.rspDelay, tag);
        join
        if (v.isWrite) begin
            checkOutput({tag, "_aw_hs_count"}, awHs - awBase, 1);
            checkOutput({tag, "_w_hs_count"},  wHs - wBase, 1);
            checkOutput({tag, "_b_hs_count"},  bHs - bBase, 1);
        end else begin
            checkOutput({tag, "_ar_hs_count"}, arHs - arBase, 1);
            checkOutput({tag, "_r_hs_count"},  rHs - rBase, 1);
        end
    endtask

    initial begin
        int  n;
        bit  quiet;
`ifdef AXIL_TIMEOUT_EN
        int  cnt;
`endif
        //         wr  addr      wdata          aw wd bd ar rd hold slvRdata      slvResp expRdata     expResp lat
        vecs[0] = '{1'b1, 13'h0040, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0,  32'h0,        2'b00, 32'h0,        2'b00, 3};
        vecs[1] = '{1'b0, 13'h0100, 32'h0,        0, 0, 0, 0, 4, 0,  32'h12345678, 2'b00, 32'h12345678, 2'b00, -1};
        vecs[2] = '{1'b1, 13'h0200, 32'hCAFEF00D, 5, 0, 0, 0, 0, 0,  32'h0,        2'b00, 32'h0,        2'b00, -1};
        vecs[3] = '{1'b0, 13'h0104, 32'h0,        0, 0, 0, 0, 0, 10, 32'hA5A5A5A5, 2'b10, 32'hA5A5A5A5, 2'b10, 3};
        vecs[4] = '{1'b1, 13'h1FFF, 32'h0,        0, 3, 2, 0, 0, 0,  32'h0,        2'b11, 32'h0,        2'b11, -1};
        vecs[5] = '{1'b0, 13'h1FFC, 32'h0,        0, 0, 0, 2, 1, 1,  32'hFFFFFFFF, 2'b01, 32'hFFFFFFFF, 2'b01, -1};
        vecs[6] = '{1'b1, 13'h0044, 32'h13579BDF, 2, 2, 0, 0, 0, 0,  32'h0,        2'b10, 32'h0,        2'b10, -1};
        vecs[7] = '{1'b0, 13'h0000, 32'h0,        0, 0, 0, 0, 0, 0,  32'h87654321, 2'b00, 32'h87654321, 2'b00, 3};

        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = '0;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0;

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_cmd_ready", bus.cmd_ready, 0);
        checkOutput("reset_awvalid",   bus.awvalid, 0);
        checkOutput("reset_wvalid",    bus.wvalid, 0);
        checkOutput("reset_arvalid",   bus.arvalid, 0);
        checkOutput("reset_rsp_valid", bus.rsp_valid, 0);
        checkOutput("reset_busy",      busy, 0);
        reset_n = 1'b1;
        #1 checkOutput("release_cmd_ready_low", bus.cmd_ready, 0);
        @(negedge clk);
        checkOutput("release_cmd_ready_high", bus.cmd_ready, 1);

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Reset while waiting for read data: everything drops at once and no response follows
        $display("[TB] reset abort during RD_DATA");
        bus.cmd_write = 1'b0; bus.cmd_addr = 13'h0300; bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < LIMIT) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
        n = 0;
        while (!bus.rready && n < LIMIT) begin @(negedge clk); n++; end
        checkOutput("abort_rready_seen", bus.rready, 1);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("abort_arvalid",   bus.arvalid, 0);
        checkOutput("abort_rready",    bus.rready, 0);
        checkOutput("abort_rsp_valid", bus.rsp_valid, 0);
        checkOutput("abort_cmd_ready", bus.cmd_ready, 0);
        checkOutput("abort_busy",      busy, 0);
        quiet = 1;
        bus.rvalid = 1'b1; bus.rdata = 32'h5555AAAA;
        repeat (3) begin @(negedge clk); if (bus.rsp_valid) quiet = 0; end
        bus.rvalid = 1'b0;
        reset_n = 1'b1;
        repeat (3) begin @(negedge clk); if (bus.rsp_valid) quiet = 0; end
        checkOutput("abort_no_response", quiet, 1);
        applyStimulus(vecs[0], "after_abort");

`ifdef AXIL_TIMEOUT_EN
        $display("[TB] read timeout with arready held low");
        checkOutput("tmo_err_initial", timeoutErr, 0);
        bus.cmd_write = 1'b0; bus.cmd_addr = 13'h0400; bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < LIMIT) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        cnt = 0;
        while (bus.arvalid && cnt < LIMIT) begin @(negedge clk); cnt++; end
        checkOutput("tmo_arvalid_cycles", cnt, 16);
        checkOutput("tmo_rsp_valid", bus.rsp_valid, 1);
        checkOutput("tmo_rsp_resp",  bus.rsp_resp, 2'b10);
        checkOutput("tmo_rsp_rdata", bus.rsp_rdata, 0);
        checkOutput("tmo_err_set",   timeoutErr, 1);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        applyStimulus(vecs[7], "tmo_after");
        checkOutput("tmo_err_sticky", timeoutErr, 1);
`endif

        checkOutput("sb_drain", sbQ.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
